// File: rtl/local_predictor_sequencer_if.sv
// Handshake and table-port bundle for local_predictor_sequencer.
// slave = sequencer side, master = requester/table side.
interface local_predictor_sequencer_if #(
    parameter int unsigned IDX_W = 10
);
    logic             lk_valid;
    logic             lk_ready;
    logic [IDX_W-1:0] lk_idx;
    logic             pred_valid;
    logic             pred_taken;
    logic [2:0]       pred_ctr;
    logic             up_valid;
    logic             up_ready;
    logic [IDX_W-1:0] up_idx;
    logic             up_taken;
    logic             tbl_en;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [2:0]       tbl_wdata;
    logic [2:0]       tbl_rdata;

    modport slave (
        input  lk_valid, lk_idx, up_valid, up_idx, up_taken, tbl_rdata,
        output lk_ready, pred_valid, pred_taken, pred_ctr, up_ready,
               tbl_en, tbl_we, tbl_addr, tbl_wdata
    );

    modport master (
        output lk_valid, lk_idx, up_valid, up_idx, up_taken, tbl_rdata,
        input  lk_ready, pred_valid, pred_taken, pred_ctr, up_ready,
               tbl_en, tbl_we, tbl_addr, tbl_wdata
    );
endinterface

// File: rtl/local_predictor_sequencer.sv
// Local predictor sequencer: lookups and queued read-modify-write counter updates
// share one single-port table. Define LP_SEQ_STALL_CNT_EN to add the stall_cnt output.
module local_predictor_sequencer #(
    parameter int unsigned IDX_W    = 10,
    parameter int unsigned UQ_DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    local_predictor_sequencer_if.slave     bus,
    output logic                           busy
`ifdef LP_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]                    stall_cnt
`endif
);
    localparam int unsigned PTR_W = $clog2(UQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, UPD_RD, UPD_WR} state_e;

    state_e             state_q, state_d;
    logic [IDX_W:0]     uq_q [UQ_DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         ctr_q, ctr_d;
    logic               pred_valid_q, pred_valid_d;

    logic               full, lk_fire, up_fire, pop;
    logic [IDX_W-1:0]   head_idx;
    logic               head_taken;
    logic [2:0]         new_ctr;

    assign full        = (count_q == CNT_W'(UQ_DEPTH));
    assign bus.lk_ready = (state_q == IDLE) && !full;
    assign bus.up_ready = !full;
    assign lk_fire     = bus.lk_valid && bus.lk_ready;
    assign up_fire     = bus.up_valid && bus.up_ready;
    assign pop         = (state_q == UPD_WR);
    assign {head_idx, head_taken} = uq_q[head_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            ctr_q        <= '0;
            pred_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            ctr_q        <= ctr_d;
            pred_valid_q <= pred_valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (up_fire) uq_q[tail_q] <= {bus.up_idx, bus.up_taken};
    end

    // Lookups win IDLE; a full queue blocks lookups, so updates cannot starve.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!lk_fire && count_q != '0) state_d = UPD_RD;
            UPD_RD:  state_d = UPD_WR;
            UPD_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d       = pop ? head_q + PTR_W'(1) : head_q;
        tail_d       = up_fire ? tail_q + PTR_W'(1) : tail_q;
        count_d      = count_q + CNT_W'(up_fire) - CNT_W'(pop);
        ctr_d        = (state_q == UPD_RD) ? bus.tbl_rdata : ctr_q;
        pred_valid_d = lk_fire;
        if (head_taken) new_ctr = (ctr_q == 3'd7) ? 3'd7 : ctr_q + 3'd1;
        else            new_ctr = (ctr_q == 3'd0) ? 3'd0 : ctr_q - 3'd1;
    end

    always_comb begin
        bus.tbl_en    = 1'b0;
        bus.tbl_we    = 1'b0;
        bus.tbl_addr  = '0;
        bus.tbl_wdata = '0;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (lk_fire) begin
                        bus.tbl_en   = 1'b1;
                        bus.tbl_addr = bus.lk_idx;
                    end else if (count_q != '0) begin
                        bus.tbl_en   = 1'b1;
                        bus.tbl_addr = head_idx;
                    end
                end
                UPD_WR: begin
                    bus.tbl_en    = 1'b1;
                    bus.tbl_we    = 1'b1;
                    bus.tbl_addr  = head_idx;
                    bus.tbl_wdata = new_ctr;
                end
                default: ;
            endcase
        end
    end

    // Read data is only meaningful in the cycle after an accepted lookup.
    assign bus.pred_valid = pred_valid_q && !reset;
    assign bus.pred_ctr   = bus.pred_valid ? bus.tbl_rdata : '0;
    assign bus.pred_taken = (bus.pred_ctr > 3'd3);
    assign busy           = !reset && ((count_q != '0) || (state_q != IDLE));

`ifdef LP_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (bus.lk_valid && !bus.lk_ready && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_local_predictor_sequencer.sv
// Scoreboard bench for local_predictor_sequencer with a behavioural single-port table.
module tb_local_predictor_sequencer;
    localparam int unsigned IDX_W    = 10;
    localparam int unsigned UQ_DEPTH = 4;
    localparam int unsigned TBL_N    = 1 << IDX_W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy;
`ifdef LP_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clock = ~clock;

    local_predictor_sequencer_if #(.IDX_W(IDX_W)) bus();

    local_predictor_sequencer #(.IDX_W(IDX_W), .UQ_DEPTH(UQ_DEPTH)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy)
`ifdef LP_SEQ_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned nwr = 0;
    int unsigned push_in_wr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] init_val(input int unsigned i);
        case (i)
            'h05:    return 3'd6;
            'h10:    return 3'd7;
            'h11:    return 3'd0;
            'h50:    return 3'd3;
            default: return 3'((i * 3 + (i >> 4)) % 8);
        endcase
    endfunction

    // Behavioural table: one access per cycle, read data one cycle later.
    logic [2:0] mem [TBL_N];
    logic       mem_loaded = 1'b0;
    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < TBL_N; i++) mem[i] = init_val(i);
            mem_loaded = 1'b1;
        end
        if (bus.tbl_en) begin
            if (bus.tbl_we) mem[bus.tbl_addr] = bus.tbl_wdata;
            else            bus.tbl_rdata <= mem[bus.tbl_addr];
        end
    end

    // ref_mem: table after all accepted updates; cmt_mem: after updates written so far.
    logic [2:0]         ref_mem [TBL_N];
    logic [2:0]         cmt_mem [TBL_N];
    logic               sb_loaded = 1'b0;
    logic [2:0]         lk_q [$];
    logic [IDX_W+2:0]   wr_q [$];

    always @(negedge clock) begin
        logic [2:0]         e, o, n;
        logic [IDX_W+2:0]   w;
        if (!sb_loaded) begin
            for (int i = 0; i < TBL_N; i++) begin
                ref_mem[i] = init_val(i);
                cmt_mem[i] = init_val(i);
            end
            sb_loaded = 1'b1;
        end
        if (reset) begin
            check("rst_tbl_en", bus.tbl_en, 0);
            lk_q.delete();
            wr_q.delete();
            for (int i = 0; i < TBL_N; i++) ref_mem[i] = cmt_mem[i];
        end else begin
            if (bus.pred_valid) begin
                if (lk_q.size() == 0) check("pred_unexpected", bus.pred_valid, 0);
                else begin
                    e = lk_q.pop_front();
                    check("pred_ctr", bus.pred_ctr, e);
                    check("pred_taken", bus.pred_taken, (e > 3));
                end
            end
            if (bus.tbl_en && bus.tbl_we) begin
                nwr++;
                if (bus.up_valid && bus.up_ready) push_in_wr++;
                if (wr_q.size() == 0) check("write_unexpected", bus.tbl_we, 0);
                else begin
                    w = wr_q.pop_front();
                    check("wr_addr", bus.tbl_addr, w[IDX_W+2:3]);
                    check("wr_data", bus.tbl_wdata, w[2:0]);
                    cmt_mem[w[IDX_W+2:3]] = w[2:0];
                end
            end
            if (bus.lk_valid && bus.lk_ready) lk_q.push_back(cmt_mem[bus.lk_idx]);
            if (bus.up_valid && bus.up_ready) begin
                o = ref_mem[bus.up_idx];
                if (bus.up_taken) n = (o == 3'd7) ? 3'd7 : o + 3'd1;
                else              n = (o == 3'd0) ? 3'd0 : o - 3'd1;
                ref_mem[bus.up_idx] = n;
                wr_q.push_back({bus.up_idx, n});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic push_upd(input logic [IDX_W-1:0] idx, input logic taken);
        int unsigned k = 0;
        logic acc;
        bus.up_valid = 1'b1;
        bus.up_idx   = idx;
        bus.up_taken = taken;
        do begin
            @(negedge clock);
            acc = bus.up_ready;
            tick();
            k++;
        end while (!acc && k < 50);
        bus.up_valid = 1'b0;
        if (!acc) check("up_accept_timeout", acc, 1);
    endtask

    task automatic upd_steps(input logic [IDX_W-1:0] idx, input logic taken, input logic [2:0] exp_w);
        tick();
        bus.up_valid = 1'b1; bus.up_idx = idx; bus.up_taken = taken;
        tick();
        bus.up_valid = 1'b0;
        @(negedge clock);
        check("idle_rd_en", bus.tbl_en, 1);
        check("idle_rd_we", bus.tbl_we, 0);
        check("idle_rd_addr", bus.tbl_addr, idx);
        tick();
        @(negedge clock);
        check("updrd_no_access", bus.tbl_en, 0);
        check("updrd_busy", busy, 1);
        tick();
        @(negedge clock);
        check("updwr_we", bus.tbl_we, 1);
        check("updwr_addr", bus.tbl_addr, idx);
        check("updwr_data", bus.tbl_wdata, exp_w);
        tick();
        @(negedge clock);
        check("upd_done_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k, blk, j, nwr0, piw0;
        logic acc;
        bus.lk_valid = 1'b0; bus.lk_idx = '0;
        bus.up_valid = 1'b0; bus.up_idx = '0; bus.up_taken = 1'b0;
        bus.tbl_rdata = '0;

        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_pred_valid", bus.pred_valid, 0);
        check("rst_pred_ctr", bus.pred_ctr, 0);
        check("rst_pred_taken", bus.pred_taken, 0);
        check("rst_tbl_we", bus.tbl_we, 0);
        check("rst_tbl_addr", bus.tbl_addr, 0);
        check("rst_tbl_wdata", bus.tbl_wdata, 0);
        check("rst_lk_ready", bus.lk_ready, 1);
        check("rst_up_ready", bus.up_ready, 1);
`ifdef LP_SEQ_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 0);
`endif

        // Single lookup with one-cycle latency, then back-to-back lookups.
        tick();
        bus.lk_valid = 1'b1; bus.lk_idx = 'h05;
        tick();
        bus.lk_valid = 1'b0;
        @(negedge clock);
        check("lk05_valid", bus.pred_valid, 1);
        check("lk05_ctr", bus.pred_ctr, 6);
        check("lk05_taken", bus.pred_taken, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.lk_valid = 1'b1;
            bus.lk_idx   = IDX_W'($urandom_range(0, TBL_N - 1));
            tick();
        end
        bus.lk_valid = 1'b0;
        tick();
        @(negedge clock);

        // Saturation at both ends of the counter.
        upd_steps('h10, 1'b1, 3'd7);
        upd_steps('h11, 1'b0, 3'd0);

        // Fill the queue under continuous lookups; lookups block until one pop.
        tick();
        bus.lk_valid = 1'b1; bus.lk_idx = 'h20;
        nwr0 = nwr;
        for (int i = 0; i < 4; i++) push_upd(IDX_W'('h30 + i), i[0]);
        @(negedge clock);
        check("full_lk_ready", bus.lk_ready, 0);
        check("full_up_ready", bus.up_ready, 0);
        check("full_head_rd", bus.tbl_en, 1);
        k = 0;
        while (!bus.lk_ready && k < 20) begin
            tick();
            k++;
        end
        check("lk_ready_back", bus.lk_ready, 1);
        check("writes_before_ready", nwr - nwr0, 1);
        check("busy_at_count3", busy, 1);
        bus.lk_valid = 1'b0;
        wait_idle(50);

        // Lookup and update to the same index in one cycle: lookup sees old value.
        tick();
        bus.lk_valid = 1'b1; bus.lk_idx = 'h50;
        bus.up_valid = 1'b1; bus.up_idx = 'h50; bus.up_taken = 1'b1;
        tick();
        bus.lk_valid = 1'b0; bus.up_valid = 1'b0;
        @(negedge clock);
        check("same_idx_pre", bus.pred_ctr, 3);
        wait_idle(50);
        tick();
        bus.lk_valid = 1'b1; bus.lk_idx = 'h50;
        tick();
        bus.lk_valid = 1'b0;
        @(negedge clock);
        check("same_idx_post", bus.pred_ctr, 4);

        // Back-to-back pushes: one lands during UPD_WR at count=3, pointers wrap.
        piw0 = push_in_wr;
        push_upd('h40, 1'b1);
        push_upd('h40, 1'b1);
        push_upd('h41, 1'b0);
        push_upd('h40, 1'b0);
        push_upd('h42, 1'b1);
        push_upd('h43, 1'b1);
        push_upd('h41, 1'b1);
        check("push_during_wr", (push_in_wr != piw0), 1);
        wait_idle(100);

        // Reset while in UPD_RD drops the pending update.
        tick();
        nwr0 = nwr;
        bus.up_valid = 1'b1; bus.up_idx = 'h60; bus.up_taken = 1'b1;
        tick();
        bus.up_valid = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clock);
        check("rst_updrd_en", bus.tbl_en, 0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_busy", busy, 0);
        check("post_rst_en", bus.tbl_en, 0);
        check("post_rst_up_ready", bus.up_ready, 1);
`ifdef LP_SEQ_STALL_CNT_EN
        check("post_rst_stall", stall_cnt, 0);
`endif
        repeat (5) tick();
        check("no_write_after_rst", nwr - nwr0, 0);
        check("tbl60_unchanged", mem['h60], cmt_mem['h60]);

        // Sustained contention until exactly ten lookup cycles have been blocked.
        blk = 0; j = 0; k = 0;
        bus.lk_valid = 1'b1; bus.lk_idx = 'h20;
        bus.up_valid = 1'b1; bus.up_idx = 'h70; bus.up_taken = 1'b0;
        while (blk < 10 && k < 200) begin
            @(negedge clock);
            if (bus.lk_valid && !bus.lk_ready) blk++;
            acc = bus.up_ready;
            tick();
            k++;
            if (acc) begin
                j++;
                bus.up_idx   = IDX_W'('h70 + j);
                bus.up_taken = j[0];
            end
            if (blk == 10) begin
                bus.lk_valid = 1'b0;
                bus.up_valid = 1'b0;
            end
        end
        bus.lk_valid = 1'b0;
        bus.up_valid = 1'b0;
        @(negedge clock);
        check("blocked_cycles", blk, 10);
`ifdef LP_SEQ_STALL_CNT_EN
        check("stall_cnt_10", stall_cnt, 10);
`endif
        wait_idle(100);
`ifdef LP_SEQ_STALL_CNT_EN
        check("stall_cnt_hold", stall_cnt, 10);
`endif

        repeat (3) tick();
        check("lk_q_drained", lk_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/local_predictor_sequencer.md
LOCAL_PREDICTOR_SEQUENCER -- requirements
Module: local_predictor_sequencer

Interface
REQ-001 SHALL have parameter IDX_W, default 10, width of the local pattern table index.
REQ-002 SHALL have parameter UQ_DEPTH, default 4, number of entries in the update queue (power of two, at least 2).
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port lk_valid  input  1  lookup request.
REQ-006 SHALL have port lk_ready  output  1  lookup accepted this cycle when lk_valid is also high.
REQ-007 SHALL have port lk_idx  input  IDX_W  lookup index.
REQ-008 SHALL have port pred_valid  output  1  prediction result valid.
REQ-009 SHALL have port pred_taken  output  1  prediction, equal to pred_ctr > 3.
REQ-010 SHALL have port pred_ctr  output  3  raw counter that was read.
REQ-011 SHALL have ports up_valid/up_ready  input/output  1  resolved-branch update handshake.
REQ-012 SHALL have ports up_idx  input  IDX_W  and up_taken  input  1  carrying the update index and outcome.
REQ-013 SHALL have ports tbl_en/tbl_we  output  1, tbl_addr  output  IDX_W, and tbl_wdata  output  3, driving the single-port table.
REQ-014 SHALL have port tbl_rdata  input  3  table read data, valid one cycle after a read (tbl_en=1, tbl_we=0).
REQ-015 SHALL have port busy  output  1  high while queue is non-empty or state is not IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE, UPD_RD and UPD_WR, and issue at most one table access per cycle.
REQ-017 SHALL drive lk_ready = (state==IDLE) && (count<UQ_DEPTH).
REQ-018 SHALL drive up_ready = (count<UQ_DEPTH); an accepted update pushes {up_idx, up_taken} at the tail.
REQ-019 SHALL, in IDLE when lk_valid&&lk_ready, issue a read at lk_idx, then drive pred_valid=1 with pred_ctr=tbl_rdata on the next cycle only (one-cycle latency; back-to-back lookups allowed).
REQ-020 SHALL, in IDLE with no lookup accepted and count>0, issue a read of the head index and move to UPD_RD.
REQ-021 SHALL move from IDLE to UPD_RD with that read when count==UQ_DEPTH, because lookups are blocked while the queue is full (no starvation of updates).
REQ-022 SHALL, in UPD_RD, capture tbl_rdata, issue no access, and move to UPD_WR.
REQ-023 SHALL, in UPD_WR, write to the head index the value min(ctr+1,7) if taken or max(ctr-1,0) if not taken, pop the head, and return to IDLE.
REQ-024 SHALL leave count unchanged on simultaneous push and pop, and wrap the head/tail pointers modulo UQ_DEPTH.
REQ-025 SHALL not inspect queued updates on a lookup to the same index: the lookup returns the pre-update table value.

Reset
REQ-026 SHALL, on reset, set state to IDLE, count/head/tail to 0, and pred_valid, pred_taken, pred_ctr, tbl_en, tbl_we, tbl_addr, tbl_wdata and busy to 0.
REQ-027 SHALL hold tbl_en at 0 during any reset cycle and discard queued or in-flight updates when reset is asserted mid-update.

Configuration
REQ-028 SHALL, with LP_SEQ_STALL_CNT_EN defined, provide output stall_cnt (16 bits, reset 0) that increments, saturating at 0xFFFF, on every cycle with lk_valid && !lk_ready.
REQ-029 SHALL, without LP_SEQ_STALL_CNT_EN, omit the stall_cnt port and counter entirely, with no other behavioural change.

Verification
REQ-030 SHALL cover: table[0x05]=6, lookup idx 0x05 -> next cycle pred_valid=1, pred_ctr=6, pred_taken=1.
REQ-031 SHALL cover: table[0x10]=7, update taken at 0x10 -> UPD_RD then UPD_WR writes 7 (saturation); table[0x11]=0, not-taken -> writes 0.
REQ-032 SHALL cover: four updates with lk_valid held high -> queue full, lk_ready=0, queue drains, and lk_ready returns to 1 when count=3.
REQ-033 SHALL cover: push during UPD_WR with count=UQ_DEPTH-1 -> count unchanged and all updates applied in FIFO order after pointer wrap.
REQ-034 SHALL cover: reset asserted in UPD_RD -> no write issued, count=0 and busy=0 on the next cycle.
REQ-035 SHALL cover, with LP_SEQ_STALL_CNT_EN: 10 blocked lookup cycles -> stall_cnt=10.
